shift_issue_stage: RTL and testbench
====================================

# shift_issue_stage

Registered shift execution stage for the RV32 integer datapath. It accepts a decoded shift request from the ID/EX boundary, resolves the operation type and shift amount from funct3/funct7 and the immediate/register select, and evaluates the shift. It delivers the result through a two-entry skid buffer to the writeback mux using a valid/ready handshake. The stage gives one-cycle latency at full throughput, with a registered `in_ready`.

## Interface
Parameters:
- `XLEN`, default 32: datapath width; only 32 is supported.
- `TAG_W`, default 5: destination-register tag width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  stage can accept; registered.
- `in_rs1`  in  32  operand A.
- `in_rs2`  in  32  register shift amount source; bits [4:0] used.
- `in_imm_shamt`  in  5  instr[24:20], used for immediate forms.
- `in_is_imm`  in  1  1 = SLLI/SRLI/SRAI, 0 = SLL/SRL/SRA.
- `in_funct3`  in  3  instr[14:12].
- `in_funct7`  in  7  instr[31:25].
- `in_rd`  in  TAG_W  destination tag, passed through unchanged.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts.
- `out_result`  out  32  shift result.
- `out_rd`  out  TAG_W  tag for the result.
- `out_illegal`  out  1  illegal-encoding flag (see Configuration).

## Operation
- Shift type encoding:
  - 2'b00 = SRL.
  - 2'b01 = SLL.
  - 2'b10 = SRA (arithmetic, sign from bit 31).
  - 2'b11 is never generated.
- Decode:
  - `funct3` = 3'b001 gives SLL.
  - `funct3` = 3'b101 gives SRL when `funct7[5]` = 0, and SRA when `funct7[5]` = 1.
- Shift amount: `in_imm_shamt` when `in_is_imm` = 1, otherwise `in_rs2[4:0]`. The upper bits of rs2 are ignored.
- Shift amount 0 returns `in_rs1` unchanged for every type.
- Transfer rules:
  - An input transfer occurs when `in_valid && in_ready`. The result and tag are computed combinationally from the inputs and written into the buffer on the same edge.
  - An output transfer occurs when `out_valid && out_ready`.
- Buffer, main entry M and skid entry S, with states EMPTY, ONE and FULL:
  - EMPTY: on input transfer, load M and go to ONE.
  - ONE: input transfer without output transfer loads S and goes to FULL. Input with output transfer reloads M and stays in ONE. Output transfer only goes to EMPTY.
  - FULL: output transfer moves S into M and goes to ONE. No input is accepted while in FULL.
- `in_ready` = (state != FULL), registered.
- `out_valid` = (state != EMPTY). `out_result`, `out_rd` and `out_illegal` always come from M.
- Ordering is strictly FIFO; no request is dropped or duplicated.
- Output data must stay stable while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle: a request accepted at edge N is visible on the outputs after edge N.
- Throughput is 1 per cycle while `out_ready` = 1.
- Reset values:
  - State is EMPTY.
  - `out_valid` = 0.
  - `in_ready` = 1 from the first cycle after reset.
  - `out_result`, `out_rd` and `out_illegal` are all 0.
- Reset asserted mid-operation discards both entries, with no output transfer reported in that cycle.
- `out_ready` deasserting while in ONE with a new input moves the stage to FULL. `in_ready` drops on the following cycle.
- Inputs are ignored whenever `in_valid` = 0.

## Configuration
- `SHIFT_ILLEGAL_CHECK_EN` defined:
  - A request is illegal when any of the following holds:
    - `funct3` is not 001 or 101.
    - `funct3` = 001 with `funct7` != 7'b0000000.
    - `funct3` = 101 with `funct7` not 7'b0000000 or 7'b0100000.
  - An illegal request still flows through the buffer with `out_result` = 0 and `out_illegal` = 1.
- Macro not defined:
  - No check is performed and `out_illegal` is tied to 0.
  - `funct3[2]` = 0 decodes as SLL; otherwise `funct7[5]` selects SRA or SRL.

## Structure
- Shared package `shift_pkg` holds:
  - The shift-type localparams SHIFT_SRL/SHIFT_SLL/SHIFT_SRA (2 bits).
  - FUNCT3_SLL/FUNCT3_SR.
  - FUNCT7_BASE/FUNCT7_ALT.
  - The buffer state enum.
- The two-entry buffer is a sub-module, `shift_skid_buf`, parameterised on payload width (32 + TAG_W + 1). The top level contains the decode and shift logic.

## Test plan
- SRAI, rs1 = 0x80000000, imm shamt 4, `out_ready` = 1 -> one cycle later `out_result` = 0xF8000000, `out_rd` matches the request.
- SRL, rs1 = 0x80000000, rs2 = 0xFFFFFFE4 -> `out_result` = 0x08000000, since only rs2[4:0] = 4 is used.
- SLL, rs1 = 1, rs2 = 31, then shamt 0 on rs1 = 0x1234 -> 0x80000000, then 0x1234.
- Back-to-back requests A, B and C with `out_ready` held at 0 -> FULL after B and `in_ready` = 0. C is held off until released, and outputs arrive in the order A, B, C with stable data while stalled.
- `rst` pulsed while FULL -> next cycle `out_valid` = 0, `in_ready` = 1, and all outputs are 0.
- With `SHIFT_ILLEGAL_CHECK_EN`, `funct3` = 101 and `funct7` = 0x01 -> `out_illegal` = 1 and `out_result` = 0. Without the macro, the same request gives an SRL result and `out_illegal` = 0.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg
//   Shared definitions for the RV32 shift issue stage:
//   - shift-type encodings used between decode and the shifter
//   - funct3 / funct7 values that identify the shift instructions
//   - state encoding of the two-entry output buffer
package shift_pkg;

  localparam logic [1:0] SHIFT_SRL = 2'b00;
  localparam logic [1:0] SHIFT_SLL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;

  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SR  = 3'b101;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_e;

endpackage

// File: rtl/shift_skid_buf.sv
// shift_skid_buf
//   Two-entry skid buffer (main entry M, skid entry S). Output data is
//   always taken from M; S only holds a second item while the consumer
//   stalls. in_ready is a flop so it does not depend combinationally on
//   out_ready.
//
//   Handshake: a transfer happens on a rising edge where valid and ready
//   are both high; the producer holds valid and data steady until that
//   edge, and ready never depends on valid.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    producer side
//   in_data  [W-1:0]     payload to store
//   out_ready            consumer accepts (out_valid = state_dbg != BUF_EMPTY)
//   out_data [W-1:0]     payload in M
//   state_dbg [1:0]      current buffer state (buf_state_e encoding)
module shift_skid_buf
  import shift_pkg::*;
#(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   state_dbg
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] s_q, s_d;
  logic         in_ready_q;
  logic         in_xfer;
  logic         out_xfer;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = (state_q != BUF_EMPTY) && out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      BUF_EMPTY: begin
        if (in_xfer) begin
          m_d     = in_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (in_xfer && out_xfer) begin
          m_d = in_data;
        end else if (in_xfer) begin
          s_d     = in_data;
          state_d = BUF_FULL;
        end else if (out_xfer) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // in_ready is low here, so only the drain case matters.
        if (out_xfer) begin
          m_d     = s_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BUF_EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      // Registered form of (state != FULL): computed from the next state.
      in_ready_q <= (state_d != BUF_FULL);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = m_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/shift_issue_stage.sv
// shift_issue_stage
//   Registered RV32 shift execution stage. Decodes SLL/SRL/SRA (register
//   and immediate forms) from funct3/funct7, evaluates the shift and
//   stores {result, rd, illegal} in a two-entry skid buffer. One-cycle
//   latency, one result per cycle while out_ready is high.
//
//   Optional build macro SHIFT_ILLEGAL_CHECK_EN: when defined, non-shift
//   encodings are flagged through out_illegal with a zero result; when
//   undefined out_illegal is 0 and funct3[2] alone picks left/right.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid / in_ready          request handshake (in_ready registered)
//   in_rs1, in_rs2               operand and register shift amount source
//   in_imm_shamt, in_is_imm      immediate shift amount and its select
//   in_funct3, in_funct7, in_rd  decode fields and destination tag
//   out_valid / out_ready        result handshake
//   out_result, out_rd, out_illegal  result payload
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [4:0]       in_imm_shamt,
  input  logic             in_is_imm,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [TAG_W-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_rd,
  output logic             out_illegal
);

  localparam int PW = XLEN + TAG_W + 1;

  logic [1:0]      shift_type;
  logic            illegal;
  logic [4:0]      shamt;
  logic [XLEN-1:0] shift_res;
  logic [XLEN-1:0] result;
  logic [PW-1:0]   buf_in;
  logic [PW-1:0]   buf_out;
  logic [1:0]      buf_state;
  logic            unused_bits;

  assign shamt = in_is_imm ? in_imm_shamt : in_rs2[4:0];

`ifdef SHIFT_ILLEGAL_CHECK_EN
  always_comb begin
    shift_type = SHIFT_SRL;
    illegal    = 1'b1;
    case (in_funct3)
      FUNCT3_SLL: begin
        shift_type = SHIFT_SLL;
        illegal    = (in_funct7 != FUNCT7_BASE);
      end
      FUNCT3_SR: begin
        shift_type = in_funct7[5] ? SHIFT_SRA : SHIFT_SRL;
        illegal    = !((in_funct7 == FUNCT7_BASE) || (in_funct7 == FUNCT7_ALT));
      end
      default: illegal = 1'b1;
    endcase
  end
  assign unused_bits = ^in_rs2[XLEN-1:5];
`else
  always_comb begin
    shift_type = SHIFT_SRL;
    illegal    = 1'b0;
    if (!in_funct3[2]) begin
      shift_type = SHIFT_SLL;
    end else if (in_funct7[5]) begin
      shift_type = SHIFT_SRA;
    end
  end
  assign unused_bits = ^{in_rs2[XLEN-1:5], in_funct3[1:0], in_funct7[6], in_funct7[4:0]};
`endif

  always_comb begin
    case (shift_type)
      SHIFT_SLL: shift_res = in_rs1 << shamt;
      SHIFT_SRA: shift_res = $unsigned($signed(in_rs1) >>> shamt);
      default:   shift_res = in_rs1 >> shamt;
    endcase
  end

  // Illegal requests still occupy a buffer slot, but carry a zero result.
  assign result = illegal ? '0 : shift_res;
  assign buf_in = {result, in_rd, illegal};

  shift_skid_buf #(
    .W(PW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (buf_in),
    .out_ready (out_ready),
    .out_data  (buf_out),
    .state_dbg (buf_state)
  );

  assign out_valid = (buf_state != BUF_EMPTY);
  assign {out_result, out_rd, out_illegal} = buf_out;

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage
//   Directed and randomised stimulus for shift_issue_stage. Expected
//   payloads {result, rd, illegal} come from a bit-loop reference model and
//   are queued when a request is accepted, then popped when a result is
//   consumed. Honours SHIFT_ILLEGAL_CHECK_EN like the design.
module tb_shift_issue_stage;

  localparam int TAG_W = 5;
  localparam int W     = 32 + TAG_W + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_rs1;
  logic [31:0]      in_rs2;
  logic [4:0]       in_imm_shamt;
  logic             in_is_imm;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [TAG_W-1:0] in_rd;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_rd;
  logic             out_illegal;

  int checks = 0;
  int errors = 0;
  int n_in   = 0;
  int n_out  = 0;
  logic [W-1:0] exp_q[$];

  shift_issue_stage #(.XLEN(32), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm_shamt (in_imm_shamt),
    .in_is_imm    (in_is_imm),
    .in_funct3    (in_funct3),
    .in_funct7    (in_funct7),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_illegal  (out_illegal)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [31:0] rs1, input logic [31:0] rs2,
                                         input logic [4:0] imm, input logic is_imm,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [TAG_W-1:0] rd);
    logic [4:0]  sh;
    logic [31:0] r;
    logic        ill;
    sh  = is_imm ? imm : rs2[4:0];
    ill = 1'b0;
`ifdef SHIFT_ILLEGAL_CHECK_EN
    ill = !(((f3 == 3'b001) && (f7 == 7'h00)) ||
            ((f3 == 3'b101) && ((f7 == 7'h00) || (f7 == 7'h20))));
`endif
    r = rs1;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(sh)) begin
        if (!f3[2])     r = {r[30:0], 1'b0};
        else if (f7[5]) r = {r[31], r[31:1]};
        else            r = {1'b0, r[31:1]};
      end
    end
    if (ill) r = 32'h0;
    return {r, rd, ill};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor (samples at negedge) ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        check("sb_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("sb_payload", {out_result, out_rd, out_illegal}, exp_q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_rs1, in_rs2, in_imm_shamt, in_is_imm, in_funct3, in_funct7, in_rd));
        n_in++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] imm,
                       input logic is_imm, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [TAG_W-1:0] rd);
    in_rs1 = rs1; in_rs2 = rs2; in_imm_shamt = imm; in_is_imm = is_imm;
    in_funct3 = f3; in_funct7 = f7; in_rd = rd;
    in_valid = 1'b1;
  endtask

  // Hold the driven request until it is accepted; returns #1 after that edge.
  task automatic wait_accept(input bit rand_ready);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 64; i++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      if (acc) break;
    end
    check("accept_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] imm,
                      input logic is_imm, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [TAG_W-1:0] rd);
    drive(rs1, rs2, imm, is_imm, f3, f7, rd);
    wait_accept(1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] a_exp;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm_shamt = '0; in_is_imm = 1'b0;
    in_funct3 = '0; in_funct7 = '0; in_rd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_payload", {out_result, out_rd, out_illegal}, 64'd0);

    // SRAI: 0x80000000 >>> 4, visible right after the accepting edge
    out_ready = 1'b1;
    send(32'h8000_0000, 32'h0, 5'd4, 1'b1, 3'b101, 7'h20, 5'd3);
    check("srai_valid", 64'(out_valid), 64'd1);
    check("srai_result", 64'(out_result), 64'hF800_0000);
    check("srai_rd", 64'(out_rd), 64'd3);

    // SRL with rs2 upper bits set: only rs2[4:0]=4 matters
    send(32'h8000_0000, 32'hFFFF_FFE4, 5'd0, 1'b0, 3'b101, 7'h00, 5'd7);
    check("srl_result", 64'(out_result), 64'h0800_0000);

    // SLL by 31, then shamt 0 keeps rs1, and SRA by 0 keeps a negative rs1
    send(32'h1, 32'd31, 5'd0, 1'b0, 3'b001, 7'h00, 5'd9);
    check("sll31_result", 64'(out_result), 64'h8000_0000);
    send(32'h1234, 32'h0, 5'd0, 1'b1, 3'b001, 7'h00, 5'd10);
    check("sll0_result", 64'(out_result), 64'h1234);
    send(32'h8765_4321, 32'h20, 5'd0, 1'b0, 3'b101, 7'h20, 5'd11);
    check("sra0_result", 64'(out_result), 64'h8765_4321);
    @(posedge clk); #1;
    check("idle_empty", 64'(out_valid), 64'd0);

    // Stall: A, B fill the buffer, C waits, then order A,B,C
    out_ready = 1'b0;
    send(32'hF0F0_0000, 32'd8, 5'd0, 1'b0, 3'b101, 7'h20, 5'd1);   // A: SRA 8
    a_exp = {32'hFFF0_F000, 5'd1, 1'b0};
    send(32'h0000_00FF, 32'd4, 5'd0, 1'b0, 3'b001, 7'h00, 5'd2);   // B: SLL 4
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_a", {out_result, out_rd, out_illegal}, a_exp);
    drive(32'hAAAA_5555, 32'h0, 5'd1, 1'b1, 3'b101, 7'h00, 5'd4);   // C: SRLI 1
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_stable", {out_result, out_rd, out_illegal}, a_exp);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    wait_accept(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("abc_drained", 64'(exp_q.size()), 64'd0);

    // Reset while FULL discards everything
    out_ready = 1'b0;
    send(32'h1111_1111, 32'd1, 5'd0, 1'b0, 3'b001, 7'h00, 5'd5);
    send(32'h2222_2222, 32'd2, 5'd0, 1'b0, 3'b001, 7'h00, 5'd6);
    check("pre_rst_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    n_in = n_out;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_payload", {out_result, out_rd, out_illegal}, 64'd0);

    // funct3=101 with funct7=0x01
    out_ready = 1'b1;
    send(32'h0000_00F0, 32'd4, 5'd0, 1'b0, 3'b101, 7'h01, 5'd12);
`ifdef SHIFT_ILLEGAL_CHECK_EN
    check("illegal_flag", 64'(out_illegal), 64'd1);
    check("illegal_result", 64'(out_result), 64'd0);
`else
    check("noillegal_flag", 64'(out_illegal), 64'd0);
    check("noillegal_result", 64'(out_result), 64'h0000_000F);
`endif

    // Random traffic with random consumer back-pressure
    for (int n = 0; n < 150; n++) begin
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : (($urandom_range(0, 1) == 1) ? 3'b101 : 3'b001);
      f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
      drive($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), f3, f7,
            5'($urandom_range(0, 31)));
      wait_accept(1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 1) == 1);
      end
    end

    // Drain
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_in_out_count", 64'(n_out), 64'(n_in));
    check("final_out_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
